// File: rtl/memory_defs.sv
// Definitions shared by both ends of the cache-to-memory request interface:
// op encoding, default geometry and the responder FSM state encoding.
package memory_defs;

  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_LINE_SIZE     = 128;
  localparam int DEF_MEM_LINES     = 256;
  localparam int DEF_LATENCY       = 5;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } mem_state_t;

endpackage

// File: rtl/main_memory_line_ram.sv
// Single-port line storage with registered read data. The array powers up
// zeroed and is never cleared by reset.
module line_ram #(
  parameter int LINE_SIZE = 128,
  parameter int MEM_LINES = 256,
  parameter int IDX_W     = $clog2(MEM_LINES)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_W-1:0]     idx,
  input  logic [LINE_SIZE-1:0] wdata,
  output logic [LINE_SIZE-1:0] rdata
);

  logic [LINE_SIZE-1:0] mem [MEM_LINES] = '{default: '0};

  // Write port and registered read port share one index.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/main_memory.sv
// Line-granularity backing memory: accepts one line read/write, waits a fixed
// latency, reports completion and holds it until the cache acknowledges.
module main_memory
  import memory_defs::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int LINE_SIZE     = DEF_LINE_SIZE,
  parameter int MEM_LINES     = DEF_MEM_LINES,
  parameter int LATENCY       = DEF_LATENCY,
  parameter int OFFSET_WIDTH  = $clog2(LINE_SIZE/8)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     op,
  input  logic                     op_done,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [LINE_SIZE-1:0]     data_in,
  output logic [LINE_SIZE-1:0]     data_out,
  output logic                     data_ready,
  output logic                     memory_in_use
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = $clog2(LATENCY + 1);

  mem_state_t           state_r, state_nx;
  logic [CNT_W-1:0]     counter_r, counter_nx;
  logic                 op_r, op_nx;
  logic [IDX_W-1:0]     idx_r, idx_nx;
  logic [LINE_SIZE-1:0] wdata_r, wdata_nx;
  logic [LINE_SIZE-1:0] data_out_r, data_out_nx;
  logic                 data_ready_r, data_ready_nx;
  logic                 in_use_r, in_use_nx;

  logic [IDX_W-1:0]     addr_idx_s;
  logic [IDX_W-1:0]     ram_idx_s;
  logic                 ram_we_s;
  logic [LINE_SIZE-1:0] ram_rdata_s;
  logic                 unused_addr_bits;

  assign addr_idx_s       = address[OFFSET_WIDTH +: IDX_W];
  assign unused_addr_bits = ^address;

  // In IDLE the RAM tracks the incoming address so read data is already
  // registered by the completion edge even when LATENCY is 1.
  assign ram_idx_s = (state_r == IDLE) ? addr_idx_s : idx_r;

  line_ram #(
    .LINE_SIZE (LINE_SIZE),
    .MEM_LINES (MEM_LINES),
    .IDX_W     (IDX_W)
  ) u_line_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .idx   (ram_idx_s),
    .wdata (wdata_r),
    .rdata (ram_rdata_s)
  );

  // Next-state, request latching and completion decisions.
  always_comb begin
    state_nx      = state_r;
    counter_nx    = counter_r;
    op_nx         = op_r;
    idx_nx        = idx_r;
    wdata_nx      = wdata_r;
    data_out_nx   = data_out_r;
    data_ready_nx = data_ready_r;
    in_use_nx     = in_use_r;
    ram_we_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          op_nx      = op;
          idx_nx     = addr_idx_s;
          wdata_nx   = data_in;
          in_use_nx  = 1'b1;
          counter_nx = CNT_W'(LATENCY - 1);
          state_nx   = BUSY;
        end else begin
          state_nx   = IDLE;
        end
      end
      BUSY: begin
        if (counter_r == {CNT_W{1'b0}}) begin
          // A reset on this edge must not commit the write.
          ram_we_s      = (op_r == MEM_OP_WRITE) && !reset;
          if (op_r == MEM_OP_READ) begin
            data_out_nx = ram_rdata_s;
          end else begin
            data_out_nx = data_out_r;
          end
          data_ready_nx = 1'b1;
          state_nx      = READY;
        end else begin
          counter_nx    = counter_r - CNT_W'(1);
        end
      end
      READY: begin
        if (op_done) begin
          data_ready_nx = 1'b0;
          in_use_nx     = 1'b0;
          state_nx      = IDLE;
        end else begin
          state_nx      = READY;
        end
      end
      default: begin
        data_ready_nx = 1'b0;
        in_use_nx     = 1'b0;
        state_nx      = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      counter_r    <= {CNT_W{1'b0}};
      op_r         <= MEM_OP_READ;
      idx_r        <= {IDX_W{1'b0}};
      wdata_r      <= {LINE_SIZE{1'b0}};
      data_out_r   <= {LINE_SIZE{1'b0}};
      data_ready_r <= 1'b0;
      in_use_r     <= 1'b0;
    end else begin
      state_r      <= state_nx;
      counter_r    <= counter_nx;
      op_r         <= op_nx;
      idx_r        <= idx_nx;
      wdata_r      <= wdata_nx;
      data_out_r   <= data_out_nx;
      data_ready_r <= data_ready_nx;
      in_use_r     <= in_use_nx;
    end
  end

  assign data_out      = data_out_r;
  assign data_ready    = data_ready_r;
  assign memory_in_use = in_use_r;

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory against an array-based reference of
// line storage and the last completed read.
module tb_main_memory;

  localparam int AW  = 32;
  localparam int LS  = 128;
  localparam int ML  = 256;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          op;
  logic          op_done;
  logic [AW-1:0] address;
  logic [LS-1:0] data_in;
  logic [LS-1:0] data_out;
  logic          data_ready;
  logic          memory_in_use;

  int compared   = 0;
  int mismatched = 0;

  logic [LS-1:0] ref_mem [ML];
  logic [LS-1:0] ref_out;

  main_memory #(
    .ADDRESS_WIDTH (AW),
    .LINE_SIZE     (LS),
    .MEM_LINES     (ML),
    .LATENCY       (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .op            (op),
    .op_done       (op_done),
    .address       (address),
    .data_in       (data_in),
    .data_out      (data_out),
    .data_ready    (data_ready),
    .memory_in_use (memory_in_use)
  );

  always #5 clk = ~clk;

  function automatic int line_of(input logic [AW-1:0] a);
    return int'((a / 32'd16) % 32'd256);
  endfunction

  function automatic logic [LS-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request: accept, measure latency, check result, hold, acknowledge.
  task automatic run_op(input logic wr, input logic [AW-1:0] a, input logic [LS-1:0] d,
                        input int hold, input bit noisy, input bit enable_at_ack);
    int            k;
    int            idx;
    bit            busy_ok;
    bit            hold_ok;
    logic [LS-1:0] exp_out;
    idx     = line_of(a);
    enable  = 1'b1;
    op      = wr;
    address = a;
    data_in = d;
    tick();
    compared++;
    if (memory_in_use !== 1'b1 || data_ready !== 1'b0)
      $display("FAIL accept: in_use=%b ready=%b, required in_use=1 ready=0", memory_in_use, data_ready);
    enable = 1'b0;
    exp_out = wr ? ref_out : ref_mem[idx];
    if (wr) ref_mem[idx] = d;
    ref_out = exp_out;
    k = 0;
    busy_ok = 1'b1;
    while (data_ready !== 1'b1 && k < 50) begin
      if (noisy) begin
        address = $urandom;
        op      = ~wr;
        data_in = rand_line();
        enable  = 1'($urandom_range(0, 1));
      end
      if (memory_in_use !== 1'b1) busy_ok = 1'b0;
      tick();
      k++;
    end
    enable = 1'b0;
    op     = 1'b0;
    compared++;
    if (k !== LAT) begin
      mismatched++;
      $display("FAIL latency: data_ready after %0d edges, required %0d", k, LAT);
    end
    compared++;
    if (data_out !== exp_out) begin
      mismatched++;
      $display("FAIL data_out line %0d: got %h, required %h", idx, data_out, exp_out);
    end
    compared++;
    if (!busy_ok || memory_in_use !== 1'b1) begin
      mismatched++;
      $display("FAIL in_use_busy: memory_in_use dropped during request (now %b), required 1", memory_in_use);
    end
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (noisy) begin
        enable  = 1'($urandom_range(0, 1));
        op      = 1'($urandom_range(0, 1));
        address = $urandom;
        data_in = rand_line();
      end
      tick();
      if (data_ready !== 1'b1 || memory_in_use !== 1'b1 || data_out !== exp_out) hold_ok = 1'b0;
    end
    compared++;
    if (!hold_ok) begin
      mismatched++;
      $display("FAIL hold: ready=%b in_use=%b out=%h, required ready=1 in_use=1 out=%h",
               data_ready, memory_in_use, data_out, exp_out);
    end
    op_done = 1'b1;
    enable  = enable_at_ack;
    op      = 1'b0;
    address = $urandom;
    tick();
    op_done = 1'b0;
    enable  = 1'b0;
    compared++;
    if (data_ready !== 1'b0 || memory_in_use !== 1'b0 || data_out !== exp_out) begin
      mismatched++;
      $display("FAIL ack: ready=%b in_use=%b out=%h, required ready=0 in_use=0 out=%h",
               data_ready, memory_in_use, data_out, exp_out);
    end
  endtask

  task automatic test_reset();
    bit idle_ok;
    reset   = 1'b1;
    enable  = 1'b0;
    op      = 1'b0;
    op_done = 1'b0;
    address = '0;
    data_in = '0;
    tick();
    tick();
    reset = 1'b0;
    compared++;
    if (data_ready !== 1'b0 || memory_in_use !== 1'b0 || data_out !== '0) begin
      mismatched++;
      $display("FAIL reset: ready=%b in_use=%b out=%h, required all 0", data_ready, memory_in_use, data_out);
    end
    idle_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (data_ready !== 1'b0 || memory_in_use !== 1'b0 || data_out !== '0) idle_ok = 1'b0;
    end
    compared++;
    if (!idle_ok) begin
      mismatched++;
      $display("FAIL idle: ready=%b in_use=%b out=%h, required all 0", data_ready, memory_in_use, data_out);
    end
  endtask

  task automatic test_write_read();
    run_op(1'b1, 32'h0000_0010, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1, 1'b0, 1'b0);
    run_op(1'b0, 32'h0000_001C, '0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_alias();
    run_op(1'b1, 32'h0000_0000, {16{8'hAA}}, 0, 1'b0, 1'b0);
    run_op(1'b0, 32'h0000_1000, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_hold_ack();
    run_op(1'b0, 32'h0000_0010, '0, 20, 1'b1, 1'b1);
    tick();
    compared++;
    if (memory_in_use !== 1'b0) begin
      mismatched++;
      $display("FAIL ack_no_accept: in_use=%b, required 0", memory_in_use);
    end
  endtask

  task automatic test_reset_mid_write();
    enable  = 1'b1;
    op      = 1'b1;
    address = 32'h0000_0030;
    data_in = {16{8'h55}};
    tick();
    enable = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    ref_out = '0;
    compared++;
    if (data_ready !== 1'b0 || memory_in_use !== 1'b0 || data_out !== '0) begin
      mismatched++;
      $display("FAIL reset_mid: ready=%b in_use=%b out=%h, required all 0", data_ready, memory_in_use, data_out);
    end
    tick();
    run_op(1'b0, 32'h0000_0030, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_busy_inputs();
    run_op(1'b1, 32'h0000_0010, rand_line(), 0, 1'b0, 1'b0);
    run_op(1'b0, 32'h0000_0014, '0, 2, 1'b1, 1'b0);
    run_op(1'b0, 32'h0000_0020, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 7) * 32'd16) + $urandom_range(0, 15)
          + ($urandom_range(0, 3) * 32'd4096);
      run_op(1'($urandom_range(0, 1)), a, rand_line(), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    for (int i = 0; i < ML; i++) ref_mem[i] = '0;
    ref_out = '0;
    test_reset();
    test_write_read();
    test_alias();
    test_hold_ack();
    test_reset_mid_write();
    test_busy_inputs();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
